// File: rtl/seg_scan_ctrl_if.sv
// seg_scan_ctrl_if: load handshake between the datapath (master) and the
// seven-segment scan controller (slave). A transfer happens on a rising
// clock edge where valid and ready are both high.
interface seg_scan_ctrl_if #(
  parameter int DIGITS = 4
);
  logic                  valid;
  logic                  ready;
  logic [4*DIGITS-1:0]   value;  // nibble k = digit k, digit 0 least significant
  logic [DIGITS-1:0]     blank;  // bit k = 1 forces digit k dark

  modport master (
    output valid,
    output value,
    output blank,
    input  ready
  );

  modport slave (
    input  valid,
    input  value,
    input  blank,
    output ready
  );
endinterface

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: time-multiplexed scan controller for a multi-digit
// common-anode seven-segment display. One shared hex decoder is steered to
// the active digit; new values are double-buffered and only take effect on
// frame boundaries so a frame never shows a mix of old and new digits.
// Optional build macro: SEG_LZ_SUPPRESS_EN enables leading-zero suppression.

// Hex nibble to active-low segments, bit order a..g (o_seg[0] = a).
module hexto7segment (
  input  logic [3:0] i_hex,
  output logic [0:6] o_seg
);
  // Combinational lookup table
  always_comb begin
    o_seg = 7'b1111111;
    case (i_hex)
      4'h0: o_seg = 7'b0000001;
      4'h1: o_seg = 7'b1001111;
      4'h2: o_seg = 7'b0010010;
      4'h3: o_seg = 7'b0000110;
      4'h4: o_seg = 7'b1001100;
      4'h5: o_seg = 7'b0100100;
      4'h6: o_seg = 7'b0100000;
      4'h7: o_seg = 7'b0001111;
      4'h8: o_seg = 7'b0000000;
      4'h9: o_seg = 7'b0000100;
      4'hA: o_seg = 7'b0001000;
      4'hB: o_seg = 7'b1100000;
      4'hC: o_seg = 7'b0110001;
      4'hD: o_seg = 7'b1000010;
      4'hE: o_seg = 7'b0110000;
      4'hF: o_seg = 7'b0111000;
      default: o_seg = 7'b1111111;
    endcase
  end
endmodule

module seg_scan_ctrl #(
  parameter int DIGITS = 4,      // digits scanned, 2..8
  parameter int DIV    = 50000,  // clock cycles per digit slot, >= GAP+2
  parameter int GAP    = 500     // dark cycles at the start of every slot, >= 1
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  seg_scan_ctrl_if.slave     load,
  output logic [DIGITS-1:0]  o_an,
  output logic [0:6]         o_seg,
  output logic               o_frame
);

  localparam int CW = $clog2(DIV);
  localparam int IW = $clog2(DIGITS);
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] CNT_GAP  = CW'(GAP);
  localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

  typedef enum logic {
    ST_IDLE,
    ST_SCAN
  } state_t;

  // State and buffers
  state_t                state_q,      state_d;
  logic [CW-1:0]         cnt_q,        cnt_d;
  logic [IW-1:0]         idx_q,        idx_d;
  logic [4*DIGITS-1:0]   act_val_q,    act_val_d;
  logic [DIGITS-1:0]     act_blank_q,  act_blank_d;
  logic [4*DIGITS-1:0]   pend_val_q,   pend_val_d;
  logic [DIGITS-1:0]     pend_blank_q, pend_blank_d;
  logic                  pend_v_q,     pend_v_d;

  // Registered display outputs
  logic [DIGITS-1:0]     an_q,         an_d;
  logic [0:6]            seg_q,        seg_d;
  logic                  frame_q,      frame_d;

  // Per-digit view of the active buffer
  logic [3:0]            nib [DIGITS];
  logic [DIGITS-1:0]     digit_dark;
  logic [3:0]            cur_nib;
  logic [0:6]            cur_seg;

  logic                  accept;
  logic                  slot_end;
  logic                  wrap;
  logic                  lit;

  // A digit is dark when blanked, or (optionally) when it is a leading zero.
  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
      assign nib[gi] = act_val_q[gi*4 +: 4];
`ifdef SEG_LZ_SUPPRESS_EN
      // zero_above: every higher digit is zero or blanked
      logic zero_above;
      if (gi == DIGITS - 1) begin : g_top
        assign zero_above = 1'b1;
      end else begin : g_below
        assign zero_above = g_digit[gi+1].zero_above &&
                            ((nib[gi+1] == 4'h0) || act_blank_q[gi+1]);
      end
      if (gi == 0) begin : g_lsd
        // The least significant digit always shows, so zero displays as "0".
        assign digit_dark[gi] = act_blank_q[gi];
      end else begin : g_upper
        assign digit_dark[gi] = act_blank_q[gi] ||
                                ((nib[gi] == 4'h0) && zero_above);
      end
`else
      assign digit_dark[gi] = act_blank_q[gi];
`endif
    end
  endgenerate

  assign cur_nib = nib[idx_q];

  hexto7segment u_dec (
    .i_hex (cur_nib),
    .o_seg (cur_seg)
  );

  assign load.ready = !pend_v_q;
  assign accept     = load.valid && !pend_v_q;
  assign slot_end   = (cnt_q == CNT_LAST);
  assign wrap       = (state_q == ST_SCAN) && slot_end && (idx_q == IDX_LAST);
  assign lit        = (state_q == ST_SCAN) && (cnt_q >= CNT_GAP) && !digit_dark[idx_q];

  // Next-state: scan counters, buffer handoff and handshake
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    act_val_d    = act_val_q;
    act_blank_d  = act_blank_q;
    pend_val_d   = pend_val_q;
    pend_blank_d = pend_blank_q;
    pend_v_d     = pend_v_q;

    case (state_q)
      ST_IDLE: begin
        // Nothing is on display yet, so the first load goes straight to active.
        if (accept) begin
          act_val_d   = load.value;
          act_blank_d = load.blank;
          state_d     = ST_SCAN;
          cnt_d       = '0;
          idx_d       = '0;
        end
      end

      ST_SCAN: begin
        if (slot_end) begin
          cnt_d = '0;
          idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end

        if (wrap) begin
          if (pend_v_q) begin
            act_val_d   = pend_val_q;
            act_blank_d = pend_blank_q;
            pend_v_d    = 1'b0;
          end else if (accept) begin
            // Load landing exactly on the frame boundary skips the pending stage.
            act_val_d   = load.value;
            act_blank_d = load.blank;
          end
        end else if (accept) begin
          pend_val_d   = load.value;
          pend_blank_d = load.blank;
          pend_v_d     = 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // Output decode: anodes and segments computed together so they stay aligned
  always_comb begin
    an_d    = '1;
    seg_d   = 7'b1111111;
    frame_d = wrap;
    for (int k = 0; k < DIGITS; k++) begin
      an_d[k] = !(lit && (idx_q == IW'(k)));
    end
    if (lit) begin
      seg_d = cur_seg;
    end
  end

  // State, buffer and output registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      idx_q        <= '0;
      act_val_q    <= '0;
      act_blank_q  <= '0;
      pend_val_q   <= '0;
      pend_blank_q <= '0;
      pend_v_q     <= 1'b0;
      an_q         <= '1;
      seg_q        <= 7'b1111111;
      frame_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      act_val_q    <= act_val_d;
      act_blank_q  <= act_blank_d;
      pend_val_q   <= pend_val_d;
      pend_blank_q <= pend_blank_d;
      pend_v_q     <= pend_v_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      frame_q      <= frame_d;
    end
  end

  assign o_an    = an_q;
  assign o_seg   = seg_q;
  assign o_frame = frame_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: directed bench for seg_scan_ctrl with a cycle scoreboard.
// Each cycle the expected registered outputs are pushed before the clock edge
// and popped/compared just after it.
module tb_seg_scan_ctrl;

  localparam int DIGITS = 4;
  localparam int DIV    = 8;
  localparam int GAP    = 2;
  localparam int FRAME  = DIGITS * DIV;

  typedef struct packed {
    logic [DIGITS-1:0] an;
    logic [6:0]        seg;
    logic              frame;
  } exp_t;

  logic              clk   = 1'b0;
  logic              rst_n = 1'b0;
  logic [DIGITS-1:0] an;
  logic [0:6]        seg;
  logic              frame;

  seg_scan_ctrl_if #(.DIGITS(DIGITS)) lif ();

  seg_scan_ctrl #(
    .DIGITS (DIGITS),
    .DIV    (DIV),
    .GAP    (GAP)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .load    (lif),
    .o_an    (an),
    .o_seg   (seg),
    .o_frame (frame)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  // Spec-level model: scan position counted from the first slot start
  logic                m_scan  = 1'b0;
  int                  m_t     = 0;
  logic [4*DIGITS-1:0] m_val   = '0;
  logic [DIGITS-1:0]   m_blank = '0;
  logic [4*DIGITS-1:0] m_pval  = '0;
  logic [DIGITS-1:0]   m_pblank = '0;
  logic                m_pv    = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [6:0] hex_seg(input logic [3:0] h);
    case (h)
      4'h0: return 7'b0000001;  4'h1: return 7'b1001111;
      4'h2: return 7'b0010010;  4'h3: return 7'b0000110;
      4'h4: return 7'b1001100;  4'h5: return 7'b0100100;
      4'h6: return 7'b0100000;  4'h7: return 7'b0001111;
      4'h8: return 7'b0000000;  4'h9: return 7'b0000100;
      4'hA: return 7'b0001000;  4'hB: return 7'b1100000;
      4'hC: return 7'b0110001;  4'hD: return 7'b1000010;
      4'hE: return 7'b0110000;  default: return 7'b0111000;
    endcase
  endfunction

  function automatic logic lz_dark(input int d);
`ifdef SEG_LZ_SUPPRESS_EN
    if (d == 0) return 1'b0;
    if (m_val[d*4 +: 4] != 4'h0) return 1'b0;
    for (int j = d + 1; j < DIGITS; j++) begin
      if (m_val[j*4 +: 4] != 4'h0 && !m_blank[j]) return 1'b0;
    end
    return 1'b1;
`else
    return (d < 0);
`endif
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    int   pos;
    int   c;
    int   d;
    e.an    = '1;
    e.seg   = 7'b1111111;
    e.frame = 1'b0;
    if (m_scan) begin
      pos     = m_t % FRAME;
      c       = pos % DIV;
      d       = pos / DIV;
      e.frame = (pos == FRAME - 1);
      if (!(c < GAP) && !m_blank[d] && !lz_dark(d)) begin
        e.an[d] = 1'b0;
        e.seg   = hex_seg(m_val[d*4 +: 4]);
      end
    end
    return e;
  endfunction

  // One clock cycle: predict, clock, update model, compare
  task automatic cycle();
    exp_t e;
    logic acc;
    e = model_out();
    sb.push_back(e);
    acc = lif.valid && !m_pv;
    check("ready", 32'(lif.ready), 32'(!m_pv));
    @(posedge clk);
    #1;
    if (!m_scan) begin
      if (acc) begin
        m_val = lif.value; m_blank = lif.blank; m_scan = 1'b1; m_t = 0;
      end
    end else begin
      if ((m_t % FRAME) == FRAME - 1) begin
        if (m_pv) begin
          m_val = m_pval; m_blank = m_pblank; m_pv = 1'b0;
        end else if (acc) begin
          m_val = lif.value; m_blank = lif.blank;
        end
      end else if (acc) begin
        m_pval = lif.value; m_pblank = lif.blank; m_pv = 1'b1;
      end
      m_t++;
    end
    e = sb.pop_front();
    check("an",    32'(an),    32'(e.an));
    check("seg",   32'(seg),   32'(e.seg));
    check("frame", 32'(frame), 32'(e.frame));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic do_load(input logic [4*DIGITS-1:0] v, input logic [DIGITS-1:0] b);
    lif.valid = 1'b1;
    lif.value = v;
    lif.blank = b;
    $display("load value=%h blank=%b ready=%0d scan_pos=%0d", v, b, lif.ready, m_t % FRAME);
    cycle();
    lif.valid = 1'b0;
  endtask

  // Advance until the scan is at the given frame position (bounded)
  task automatic wait_pos(input int p);
    int n;
    n = 0;
    while (((m_t % FRAME) != p) && n < 2 * FRAME) begin
      cycle();
      n++;
    end
    check("wait_pos", 32'(m_t % FRAME), 32'(p));
  endtask

  task automatic model_reset();
    m_scan = 1'b0; m_t = 0; m_val = '0; m_blank = '0;
    m_pval = '0; m_pblank = '0; m_pv = 1'b0;
  endtask

  initial begin
    lif.valid = 1'b0;
    lif.value = '0;
    lif.blank = '0;

    // Reset state
    #12;
    check("rst_an",    32'(an),        32'(4'b1111));
    check("rst_seg",   32'(seg),       32'(7'b1111111));
    check("rst_ready", 32'(lif.ready), 32'(1'b1));
    check("rst_frame", 32'(frame),     32'(1'b0));
    #11 rst_n = 1'b1;

    // Idle: stays dark with no load
    run(100);

    // First load and two full frames
    do_load(16'h12AF, 4'b0000);
    run(2 * FRAME + 5);

    // Mid-frame load during slot 1 goes to pending until the wrap
    wait_pos(DIV + 3);
    do_load(16'h0005, 4'b0000);
    run(FRAME);

    // Load exactly on the wrap cycle with pending empty: bypass
    wait_pos(FRAME - 1);
    do_load(16'h3C7E, 4'b0000);
    run(FRAME + 4);

    // Blanked digit 2
    wait_pos(5);
    do_load(16'h8888, 4'b0100);
    run(2 * FRAME);

    // Leading-zero patterns
    wait_pos(3);
    do_load(16'h0005, 4'b0000);
    run(2 * FRAME);
    wait_pos(3);
    do_load(16'h0000, 4'b0000);
    run(2 * FRAME);

    // Held valid with changing data: only the first beat is taken
    wait_pos(10);
    lif.valid = 1'b1;
    lif.value = 16'h4321;
    lif.blank = 4'b0000;
    $display("load value=%h blank=%b held scan_pos=%0d", lif.value, lif.blank, m_t % FRAME);
    cycle();
    lif.value = 16'h9999;
    cycle();
    cycle();
    lif.valid = 1'b0;
    run(2 * FRAME);

    // Asynchronous reset mid-slot with pending data
    wait_pos(12);
    do_load(16'hBEEF, 4'b0000);
    run(3);
    #2 rst_n = 1'b0;
    #1;
    check("arst_an",    32'(an),        32'(4'b1111));
    check("arst_seg",   32'(seg),       32'(7'b1111111));
    check("arst_ready", 32'(lif.ready), 32'(1'b1));
    check("arst_frame", 32'(frame),     32'(1'b0));
    model_reset();
    sb.delete();
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    run(20);
    do_load(16'h0001, 4'b0000);
    run(FRAME + 4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
